// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multi-cycle control FSM: state encoding,
// opcode/ALU codes and the opcode-to-control-line decode table.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic       memtoreg;
        logic       branch;
        logic       alusrc;
        logic       regdst;
        logic       jump;
        logic [3:0] alucontrol;
    } ctrl_t;

    // HALT and illegal opcodes decode to all-zero controls.
    function automatic ctrl_t decode_op(input logic [3:0] op, input logic [3:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.regdst     = 1'b1;
                c.alusrc     = 1'b1;
                c.alucontrol = funct;
            end
            OP_ADDI:  c.alucontrol = ALU_ADD;
            OP_LW: begin
                c.alucontrol = ALU_ADD;
                c.memtoreg   = 1'b1;
            end
            OP_SW:    c.alucontrol = ALU_ADD;
            OP_BEQ: begin
                c.alusrc     = 1'b1;
                c.alucontrol = ALU_SUB;
                c.branch     = 1'b1;
            end
            OP_J:     c.jump = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction/data memory request-ready handshake bundle between the
// controller (master) and the memory side (slave).
interface mc_controller_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/mc_controller_mem_wait_timer.sv
// Handshake wait counter shared by the fetch and data-memory phases; flags
// expiry once MEM_TIMEOUT unanswered request cycles have accumulated.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic req,
    input  logic ready,
    output logic expired
);
    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at the limit; a zero limit keeps the count pinned at 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (req && !ready && count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);
endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back phases.
// Optional MC_CONTROLLER_PERF_EN adds cycle_cnt/retire_cnt performance counters.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned IWIDTH      = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [IWIDTH-1:0] instr,
    input  logic              zero,
    mc_controller_if.master   mem,
    output logic              memtoreg,
    output logic              branch,
    output logic              alusrc,
    output logic              regdst,
    output logic              jump,
    output logic              regwrite,
    output logic [3:0]        alucontrol,
    output logic              pcwrite,
    output logic              irwrite,
    output logic              halted,
    output logic              illegal,
    output logic              bus_err
`ifdef MC_CONTROLLER_PERF_EN
    ,
    output logic [15:0]       cycle_cnt,
    output logic [15:0]       retire_cnt
`endif
);
    state_t     state, state_n;
    logic [3:0] opcode;
    ctrl_t      ctl;
    logic       imem_req_c, dmem_req_c, dmem_we_c;
    logic       set_illegal, set_bus_err;
    logic       wait_clear, wait_req, wait_ready, wait_expired;
    logic       unused_inputs;

    assign opcode = instr[IWIDTH-1 -: 4];
    assign ctl    = decode_op(opcode, instr[3:0]);

    // zero only steers the datapath's PC mux; the FSM never needs it.
    assign unused_inputs = ^{zero, instr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        pcwrite     = 1'b0;
        halted      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        {memtoreg, branch, alusrc, regdst, jump, alucontrol} = '0;

        case (state)
            S_IDLE: if (run) state_n = S_FETCH;
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    irwrite = 1'b1;
                    state_n = S_DECODE;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_n     = S_HALTED;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_n = S_WB;
                    OP_LW, OP_SW:      state_n = S_MEM;
                    OP_BEQ, OP_J: begin
                        pcwrite = 1'b1;
                        state_n = S_FETCH;
                    end
                    OP_HALT:           state_n = S_HALTED;
                    default: begin
                        set_illegal = 1'b1;
                        pcwrite     = 1'b1;
                        state_n     = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OP_SW);
                if (mem.dmem_ready) begin
                    if (opcode == OP_SW) begin
                        pcwrite = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_n     = S_HALTED;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                state_n  = S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            default:  state_n = S_IDLE;
        endcase

        if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            {memtoreg, branch, alusrc, regdst, jump, alucontrol} = ctl;
        end

        // Reset overrides the current state's outputs so an aborted
        // instruction cannot strobe anything in the reset cycle.
        if (reset) begin
            state_n     = S_IDLE;
            imem_req_c  = 1'b0;
            dmem_req_c  = 1'b0;
            dmem_we_c   = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            pcwrite     = 1'b0;
            halted      = 1'b0;
            set_illegal = 1'b0;
            set_bus_err = 1'b0;
            {memtoreg, branch, alusrc, regdst, jump, alucontrol} = '0;
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;

    assign wait_clear = (state_n == S_FETCH || state_n == S_MEM) && (state_n != state);
    assign wait_req   = imem_req_c | dmem_req_c;
    assign wait_ready = (imem_req_c & mem.imem_ready) | (dmem_req_c & mem.dmem_ready);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .req     (wait_req),
        .ready   (wait_ready),
        .expired (wait_expired)
    );

`ifdef MC_CONTROLLER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_HALTED) cycle_cnt <= cycle_cnt + 16'd1;
            if (pcwrite) retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction cycle timelines are
// derived from the opcode and handshake delays and compared cycle by cycle.
module tb_mc_controller;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset, run, zero;
    logic [15:0] instr;
    logic        memtoreg, branch, alusrc, regdst, jump, regwrite, pcwrite, irwrite;
    logic        halted, illegal, bus_err;
    logic [3:0]  alucontrol;
`ifdef MC_CONTROLLER_PERF_EN
    logic [15:0] cycle_cnt, retire_cnt;
`endif

    mc_controller_if mem_bus ();

    mc_controller #(
        .IWIDTH(16),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instr      (instr),
        .zero       (zero),
        .mem        (mem_bus),
        .memtoreg   (memtoreg),
        .branch     (branch),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .jump       (jump),
        .regwrite   (regwrite),
        .alucontrol (alucontrol),
        .pcwrite    (pcwrite),
        .irwrite    (irwrite),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err)
`ifdef MC_CONTROLLER_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       halted, irwrite, imem_req, dmem_req, dmem_we, regwrite, pcwrite;
        logic       memtoreg, branch, alusrc, regdst, jump;
        logic [3:0] alu;
    } vec_t;

    typedef struct {
        vec_t e;
        logic ri;
        logic rd;
    } step_t;

    int   n_checks = 0;
    int   n_errors = 0;
    logic m_illegal, m_buserr;
    int   m_cycles, m_retires;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.halted   = halted;
        v.irwrite  = irwrite;
        v.imem_req = mem_bus.imem_req;
        v.dmem_req = mem_bus.dmem_req;
        v.dmem_we  = mem_bus.dmem_we;
        v.regwrite = regwrite;
        v.pcwrite  = pcwrite;
        v.memtoreg = memtoreg;
        v.branch   = branch;
        v.alusrc   = alusrc;
        v.regdst   = regdst;
        v.jump     = jump;
        v.alu      = alucontrol;
        return v;
    endfunction

    // Control lines expected for an instruction word, straight from the opcode table.
    function automatic vec_t ctl_of(input logic [15:0] w);
        vec_t v;
        v = '0;
        case (w[15:12])
            4'h0: begin v.regdst = 1'b1; v.alusrc = 1'b1; v.alu = w[3:0]; end
            4'h1: v.alu = 4'b0010;
            4'h2: begin v.alu = 4'b0010; v.memtoreg = 1'b1; end
            4'h3: v.alu = 4'b0010;
            4'h4: begin v.alusrc = 1'b1; v.alu = 4'b0110; v.branch = 1'b1; end
            4'h5: v.jump = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check_cycle(input string tag, input vec_t e);
        chk(tag, 16'(observe()), 16'(e));
        chk($sformatf("%s_flags", tag), {14'b0, illegal, bus_err}, {14'b0, m_illegal, m_buserr});
    endtask

    task automatic check_perf(input string tag);
`ifdef MC_CONTROLLER_PERF_EN
        chk($sformatf("%s_cycle_cnt", tag), cycle_cnt, m_cycles[15:0]);
        chk($sformatf("%s_retire_cnt", tag), retire_cnt, m_retires[15:0]);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic clear_model();
        m_illegal = 1'b0;
        m_buserr  = 1'b0;
        m_cycles  = 0;
        m_retires = 0;
    endtask

    task automatic idle_cycle(input string tag, input logic go);
        run                = go;
        zero               = 1'($urandom);
        instr              = 16'($urandom);
        mem_bus.imem_ready = 1'($urandom);
        mem_bus.dmem_ready = 1'($urandom);
        #4 check_cycle(tag, '0);
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        run                = 1'($urandom);
        mem_bus.imem_ready = 1'($urandom);
        mem_bus.dmem_ready = 1'($urandom);
        #4 chk("reset_outputs", 16'(observe()), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        idle_cycle("idle_after_reset", 1'b0);
    endtask

    // Timeline: fetch waits, decode, exec, memory waits, write-back; a delay
    // beyond TO never answers and the phase times out into HALTED.
    task automatic do_instr(input logic [15:0] w, input int fd, input int md,
                            input int abort_at, input string tag);
        step_t      q[$];
        step_t      s;
        vec_t       c;
        logic [3:0] op;
        bit         to, legal, is_ill;
        int         ill_idx;
        op      = w[15:12];
        c       = ctl_of(w);
        legal   = (op <= 4'h5) || (op == 4'hF);
        is_ill  = !legal;
        ill_idx = -1;
        to      = 1'b0;
        for (int i = 0; i <= fd && i <= TO; i++) begin
            s.e = '0; s.e.imem_req = 1'b1; s.e.irwrite = (i == fd);
            s.ri = (i == fd); s.rd = 1'b0;
            q.push_back(s);
        end
        if (fd > TO) to = 1'b1;
        if (!to) begin
            s.e = c; s.ri = 1'b0; s.rd = 1'b0;
            q.push_back(s);
            s.e.pcwrite = (op == 4'h4) || (op == 4'h5) || is_ill;
            q.push_back(s);
            if (is_ill) ill_idx = q.size();
            if (op == 4'h2 || op == 4'h3) begin
                for (int i = 0; i <= md && i <= TO; i++) begin
                    s.e = c; s.e.dmem_req = 1'b1; s.e.dmem_we = (op == 4'h3);
                    s.e.pcwrite = (op == 4'h3) && (i == md);
                    s.ri = 1'b0; s.rd = (i == md);
                    q.push_back(s);
                end
                if (md > TO) to = 1'b1;
            end
            if (!to && (op == 4'h0 || op == 4'h1 || op == 4'h2)) begin
                s.e = c; s.e.regwrite = 1'b1; s.e.pcwrite = 1'b1;
                s.ri = 1'b0; s.rd = 1'b0;
                q.push_back(s);
            end
        end
        for (int k = 0; k < q.size(); k++) begin
            if (k == ill_idx) m_illegal = 1'b1;
            instr              = w;
            zero               = 1'($urandom);
            run                = 1'($urandom);
            mem_bus.imem_ready = q[k].e.imem_req ? q[k].ri : 1'($urandom);
            mem_bus.dmem_ready = q[k].e.dmem_req ? q[k].rd : 1'($urandom);
            if (k == abort_at) begin
                reset = 1'b1;
                #4 chk($sformatf("%s_reset_cycle", tag), 16'(observe()), 16'h0000);
                @(posedge clk); #1;
                reset = 1'b0;
                clear_model();
                return;
            end
            #4 check_cycle($sformatf("%s_c%0d", tag, k), q[k].e);
            m_cycles++;
            if (q[k].e.pcwrite) m_retires++;
            @(posedge clk); #1;
        end
        if (is_ill) m_illegal = 1'b1;
        if (to) m_buserr = 1'b1;
    endtask

    task automatic check_halted(input string tag, input int n);
        vec_t e;
        e = '0;
        e.halted = 1'b1;
        for (int i = 0; i < n; i++) begin
            run                = 1'($urandom);
            zero               = 1'($urandom);
            instr              = 16'($urandom);
            mem_bus.imem_ready = 1'($urandom);
            mem_bus.dmem_ready = 1'($urandom);
            #4 check_cycle($sformatf("%s_%0d", tag, i), e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w;
        int          r;
        reset = 1'b1; run = 1'b0; zero = 1'b0; instr = '0;
        mem_bus.imem_ready = 1'b0; mem_bus.dmem_ready = 1'b0;
        clear_model();

        do_reset();
        idle_cycle("idle_run", 1'b1);
        do_instr(16'h06C2, 0, 0, -1, "rtype");
        do_instr(16'h2345, 0, 3, -1, "lw_wait3");
        do_instr(16'h4123, 0, 0, -1, "beq");
        do_instr(16'h5ABC, 0, 0, -1, "j");
        do_instr(16'h3111, 2, TO, -1, "sw_ready_at_limit");
        do_instr(16'h1222, TO, 0, -1, "addi_fetch_at_limit");

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 7));
            w = 16'($urandom);
            w[15:12] = (r < 6) ? 4'(r) : 4'($urandom_range(6, 14));
            do_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, "rand");
        end
        check_perf("after_random");

        do_instr(16'hA000, 0, 0, -1, "illegal");
        do_instr(16'hF000, 1, 0, -1, "halt");
        check_halted("halted", 5);
        check_perf("after_halt");

        do_reset();
        idle_cycle("idle_run_sw", 1'b1);
        do_instr(16'h3456, 0, 1000, -1, "sw_timeout");
        check_halted("sw_timeout_halted", 4);
        check_perf("after_sw_timeout");

        do_reset();
        idle_cycle("idle_run_fetch", 1'b1);
        do_instr(16'h1000, 1000, 0, -1, "fetch_timeout");
        check_halted("fetch_timeout_halted", 2);

        do_reset();
        idle_cycle("idle_run_abort", 1'b1);
        do_instr(16'h2000, 0, 1000, 5, "lw_abort");
        idle_cycle("idle_after_abort", 1'b0);
        idle_cycle("idle_run_restart", 1'b1);
        do_instr(16'h06C2, 0, 0, -1, "rtype_restart");
        check_perf("after_restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
